// File: rtl/vend_ctrl_if.sv
// ============================================================================
// Module      : vend_ctrl_if
// Description : Handshake bundle between the coin/dispense front end and the
//               vending controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vend_ctrl_if;
  logic [1:0] coin;
  logic       sel;
  logic       cancel;
  logic       disp_ack;
  logic       chg_ack;
  logic       disp_req;
  logic       chg_req;
  logic [2:0] credit;
  logic       coin_rej;
  logic       busy;

  modport master (
    output coin, sel, cancel, disp_ack, chg_ack,
    input  disp_req, chg_req, credit, coin_rej, busy
  );

  modport slave (
    input  coin, sel, cancel, disp_ack, chg_ack,
    output disp_req, chg_req, credit, coin_rej, busy
  );
endinterface

`default_nettype wire

// File: rtl/vend_ctrl.sv
// ============================================================================
// Module      : vend_ctrl
// Description : Coin-operated vending controller: credit accumulation, sale,
//               change return one 50-cent unit at a time, and idle refund.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_ctrl #(
  parameter int PRICE   = 3,
  parameter int MAXCRED = 6,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  vend_ctrl_if.slave bus_io
);

  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [2:0]       C_PRICE    = 3'(PRICE);
  localparam logic [3:0]       C_MAXCRED  = 4'(MAXCRED);
  localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CREDIT   = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       credit_q, credit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             coin_rej_q, coin_rej_d;
  logic             disp_req_q, chg_req_q, busy_q;

  logic [1:0] coin_val;
  logic       coin_valid;
  logic [3:0] coin_sum;
  logic       coin_fits;
  logic       in_credit;
  logic       cancel_ok;
  logic       sel_ok;
  logic       tmo_exp;
  logic       coin_ok;

  // Qualification of the sampled requests against the current state.
  always_comb begin
    coin_val   = (bus_io.coin == 2'b01) ? 2'd1 :
                 (bus_io.coin == 2'b10) ? 2'd2 : 2'd0;
    coin_valid = (coin_val != 2'd0);
    coin_sum   = {1'b0, credit_q} + {2'b00, coin_val};
    coin_fits  = (coin_sum <= C_MAXCRED);
    in_credit  = (state_q == S_CREDIT);
    cancel_ok  = in_credit && bus_io.cancel;
    sel_ok     = in_credit && bus_io.sel && !bus_io.cancel && (credit_q >= C_PRICE);
    tmo_exp    = in_credit && (cnt_q == C_TMO_LAST) &&
                 !bus_io.sel && !bus_io.cancel && !coin_valid;
    coin_ok    = coin_valid && coin_fits &&
                 ((state_q == S_IDLE) || in_credit) &&
                 !cancel_ok && !sel_ok && !tmo_exp;
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    cnt_d      = cnt_q;
    coin_rej_d = coin_valid && !coin_ok;

    case (state_q)
      S_IDLE: begin
        if (coin_ok) begin
          state_d  = S_CREDIT;
          credit_d = coin_sum[2:0];
          cnt_d    = '0;
        end
      end

      S_CREDIT: begin
        if (cancel_ok) begin
          state_d = S_CHANGE;
          cnt_d   = '0;
        end else if (sel_ok) begin
          state_d  = S_DISPENSE;
          credit_d = credit_q - C_PRICE;
          cnt_d    = '0;
        end else if (coin_ok) begin
          credit_d = coin_sum[2:0];
          cnt_d    = '0;
        end else if (tmo_exp) begin
          state_d = S_CHANGE;
          cnt_d   = '0;
        end else if (cnt_q != C_TMO_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DISPENSE: begin
        if (bus_io.disp_ack) begin
          state_d = (credit_q != 3'd0) ? S_CHANGE : S_IDLE;
        end
      end

      S_CHANGE: begin
        // An empty CHANGE cannot be entered; the guard only keeps credit from wrapping.
        if (credit_q == 3'd0) begin
          state_d = S_IDLE;
        end else if (bus_io.chg_ack) begin
          credit_d = credit_q - 3'd1;
          if (credit_q == 3'd1) begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d  = S_IDLE;
        credit_d = 3'd0;
        cnt_d    = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      credit_q   <= 3'd0;
      cnt_q      <= '0;
      coin_rej_q <= 1'b0;
      disp_req_q <= 1'b0;
      chg_req_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      cnt_q      <= cnt_d;
      coin_rej_q <= coin_rej_d;
      disp_req_q <= (state_d == S_DISPENSE);
      chg_req_q  <= (state_d == S_CHANGE);
      busy_q     <= (state_d == S_DISPENSE) || (state_d == S_CHANGE);
    end
  end

  assign bus_io.disp_req = disp_req_q;
  assign bus_io.chg_req  = chg_req_q;
  assign bus_io.credit   = credit_q;
  assign bus_io.coin_rej = coin_rej_q;
  assign bus_io.busy     = busy_q;

endmodule

`default_nettype wire
